// File: rtl/mul_sched_if.sv
// Bus interface for mul_sched: requester handshake, multiplier issue/return,
// tagged result and flush/drain control. The perf counter signals exist only
// when MUL_SCHED_PERF_EN is defined.
interface mul_sched_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic [W-1:0]       mul_a;
  logic [W-1:0]       mul_b;
  logic               mul_vld;
  logic [2*W-1:0]     mul_res;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [2*W-1:0]     rsp_data;
  logic               flush;
  logic               flush_done;
  logic               busy;
`ifdef MUL_SCHED_PERF_EN
  logic [15:0]        perf_issue_cnt;
  logic [15:0]        perf_stall_cnt;
`endif

  // Environment side: requesters, multiplier model and flush controller
  modport master (
    output req_valid, req_a, req_b, mul_res, flush,
    input  req_ready, mul_a, mul_b, mul_vld, rsp_valid, rsp_id, rsp_data,
           flush_done, busy
`ifdef MUL_SCHED_PERF_EN
    , input perf_issue_cnt, perf_stall_cnt
`endif
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_a, req_b, mul_res, flush,
    output req_ready, mul_a, mul_b, mul_vld, rsp_valid, rsp_id, rsp_data,
           flush_done, busy
`ifdef MUL_SCHED_PERF_EN
    , output perf_issue_cnt, perf_stall_cnt
`endif
  );
endinterface

// File: rtl/mul_sched.sv
// mul_sched: round-robin scheduler sharing one pipelined multiplier among
// N_REQ requesters. Each issued operand pair carries its requester ID down a
// tag pipeline matched to the multiplier latency so products come back tagged.
// A flush/drain FSM lets upstream control quiesce the multiplier.
// Optional macro MUL_SCHED_PERF_EN adds saturating issue/stall counters.
module mul_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  mul_sched_if.slave  bus
);
  localparam int ID_W = $clog2(N_REQ);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic [N_REQ-1:0] grant;
  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic [W-1:0]     sel_a, sel_b;

  logic [W-1:0]     mul_a_q, mul_b_q;
  logic             mul_vld_q;

  // Tag entry k is visible k+1 cycles after the accept; entry LAT lines up
  // with the product on mul_res.
  logic [LAT:0]     tag_vld_q;
  logic [ID_W-1:0]  tag_id_q [LAT+1];

  logic             rsp_valid_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [2*W-1:0]   rsp_data_q;
  logic             busy;

  // Round-robin search starting at ptr; blocked outside RUN
  always_comb begin
    int idx;
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    if (state_q == RUN) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (int'(ptr_q) + k) % N_REQ;
        if (!grant_any && bus.req_valid[ID_W'(idx)]) begin
          grant_any             = 1'b1;
          grant[ID_W'(idx)]     = 1'b1;
          grant_id              = ID_W'(idx);
        end
      end
    end
  end

  // Operand mux for the granted requester and next pointer
  always_comb begin
    sel_a = bus.req_a[grant_id*W +: W];
    sel_b = bus.req_b[grant_id*W +: W];
    ptr_d = grant_any ? ID_W'((int'(grant_id) + 1) % N_REQ) : ptr_q;
  end

  assign busy = mul_vld_q | (|tag_vld_q) | rsp_valid_q;

  // Flush/drain state transitions
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.flush) state_d = DRAIN;
      DRAIN:   if (!busy)     state_d = DONE;
      DONE:    if (!bus.flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Control state: FSM and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Issue register: operands hold when nothing is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_vld_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
    end else begin
      mul_vld_q <= grant_any;
      if (grant_any) begin
        mul_a_q <= sel_a;
        mul_b_q <= sel_b;
      end
    end
  end

  // Tag pipeline shifted in step with the issue register
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int k = 0; k <= LAT; k++) tag_id_q[k] <= '0;
    end else begin
      tag_vld_q   <= {tag_vld_q[LAT-1:0], grant_any};
      tag_id_q[0] <= grant_id;
      for (int k = 1; k <= LAT; k++) tag_id_q[k] <= tag_id_q[k-1];
    end
  end

  // Result register: pulse on valid, id/data hold between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= tag_vld_q[LAT];
      if (tag_vld_q[LAT]) begin
        rsp_id_q   <= tag_id_q[LAT];
        rsp_data_q <= bus.mul_res;
      end
    end
  end

`ifdef MUL_SCHED_PERF_EN
  logic [15:0] issue_cnt_q, stall_cnt_q;

  // Saturating counters of accepted transfers and starved request cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant_any && issue_cnt_q != 16'hFFFF)
        issue_cnt_q <= issue_cnt_q + 16'd1;
      if ((|bus.req_valid) && !grant_any && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.perf_issue_cnt = issue_cnt_q;
  assign bus.perf_stall_cnt = stall_cnt_q;
`endif

  assign bus.req_ready  = grant;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.mul_vld    = mul_vld_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.flush_done = (state_q == DONE);
  assign bus.busy       = busy;
endmodule

// File: tb/tb_mul_sched.sv
// Directed testbench for mul_sched with a LAT=2 multiplier model.
module tb_mul_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_sched_if #(.N_REQ(4), .W(4)) bus ();

  mul_sched #(.N_REQ(4), .W(4), .LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Two-stage multiplier model: product valid 2 cycles after the issue edge
  logic [7:0] p0 = 8'd0, p1 = 8'd0;
  always @(posedge clk) begin
    p0 <= {4'd0, bus.mul_a} * {4'd0, bus.mul_b};
    p1 <= p0;
  end
  assign bus.mul_res = p1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance to just after the next rising edge (start of the next cycle)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.flush = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_ready_comb: got %b expected %b", bus.req_ready, 4'b0001);
    end
    checks++;
    if ({bus.mul_vld, bus.mul_a, bus.mul_b} !== 9'd0) begin
      errors++; $display("FAIL reset_mul: got %h expected 0", {bus.mul_vld, bus.mul_a, bus.mul_b});
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== 11'd0) begin
      errors++; $display("FAIL reset_rsp: got %h expected 0", {bus.rsp_valid, bus.rsp_id, bus.rsp_data});
    end
    checks++;
    if ({bus.flush_done, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b expected 00", {bus.flush_done, bus.busy});
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_a[3:0] = 4'd3;
    bus.req_b[3:0] = 4'd5;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_grant: got %b expected 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if ({bus.mul_vld, bus.mul_a, bus.mul_b} !== {1'b1, 4'd3, 4'd5}) begin
      errors++; $display("FAIL single_issue: got %h expected %h", {bus.mul_vld, bus.mul_a, bus.mul_b}, {1'b1, 4'd3, 4'd5});
    end
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) begin
        tick();
        @(negedge clk);
      end
      checks++;
      if (bus.rsp_valid !== (c == 4)) begin
        errors++; $display("FAIL single_rsp_valid c%0d: got %b expected %b", c, bus.rsp_valid, (c == 4));
      end
      if (c >= 4) begin
        checks++;
        if ({bus.rsp_id, bus.rsp_data} !== {2'd0, 8'd15}) begin
          errors++; $display("FAIL single_rsp_data c%0d: got id %0d data %0d expected id 0 data 15", c, bus.rsp_id, bus.rsp_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*4 +: 4] = 4'(i * 2);
      bus.req_b[i*4 +: 4] = 4'd3;
    end
    for (int c = 0; c < 12; c++) begin
      bus.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (c < 8) begin
        checks++;
        if (bus.req_ready !== 4'(1 << (c % 4))) begin
          errors++; $display("FAIL b2b_grant c%0d: got %b expected %b", c, bus.req_ready, 4'(1 << (c % 4)));
        end
      end
      checks++;
      if (bus.rsp_valid !== (c >= 4)) begin
        errors++; $display("FAIL b2b_rsp_valid c%0d: got %b expected %b", c, bus.rsp_valid, (c >= 4));
      end
      if (c >= 4) begin
        checks++;
        if ({bus.rsp_id, bus.rsp_data} !== {2'((c - 4) % 4), 8'(((c - 4) % 4) * 6)}) begin
          errors++; $display("FAIL b2b_rsp c%0d: got id %0d data %0d expected id %0d data %0d",
                             c, bus.rsp_id, bus.rsp_data, (c - 4) % 4, ((c - 4) % 4) * 6);
        end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] vin [4];
    logic [3:0] vexp [4];
    vin[0] = 4'b0001; vexp[0] = 4'b0001;
    vin[1] = 4'b1010; vexp[1] = 4'b0010;
    vin[2] = 4'b1010; vexp[2] = 4'b1000;
    vin[3] = 4'b0001; vexp[3] = 4'b0001;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      bus.req_valid = vin[c];
      @(negedge clk);
      checks++;
      if (bus.req_ready !== vexp[c]) begin
        errors++; $display("FAIL rr_grant c%0d: got %b expected %b", c, bus.req_ready, vexp[c]);
      end
      tick();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      bus.req_valid = 4'b0001;
      bus.req_a[3:0] = 4'(c + 1);
      bus.req_b[3:0] = 4'd2;
      bus.flush = (c >= 2 && c <= 8);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== ((c <= 2 || c >= 10) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL flush_ready c%0d: got %b expected %b", c, bus.req_ready,
                           ((c <= 2 || c >= 10) ? 4'b0001 : 4'b0000));
      end
      checks++;
      if (bus.flush_done !== (c == 8 || c == 9)) begin
        errors++; $display("FAIL flush_done c%0d: got %b expected %b", c, bus.flush_done, (c == 8 || c == 9));
      end
      checks++;
      if (bus.rsp_valid !== (c >= 4 && c <= 6)) begin
        errors++; $display("FAIL flush_rsp_valid c%0d: got %b expected %b", c, bus.rsp_valid, (c >= 4 && c <= 6));
      end
      if (c >= 4 && c <= 6) begin
        checks++;
        if (bus.rsp_data !== 8'((c - 3) * 2)) begin
          errors++; $display("FAIL flush_rsp_data c%0d: got %0d expected %0d", c, bus.rsp_data, (c - 3) * 2);
        end
      end
      if (c == 6 || c == 7) begin
        checks++;
        if (bus.busy !== (c == 6)) begin
          errors++; $display("FAIL flush_busy c%0d: got %b expected %b", c, bus.busy, (c == 6));
        end
      end
      tick();
    end
    bus.req_valid = '0;
    bus.flush = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_a = 16'h0077;
    bus.req_b = 16'h0077;
    tick();
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_rsp_valid c%0d: got %b expected 0", c, bus.rsp_valid);
      end
      if (c == 0) begin
        checks++;
        if ({bus.mul_vld, bus.busy} !== 2'b00) begin
          errors++; $display("FAIL midrst_idle: got %b expected 00", {bus.mul_vld, bus.busy});
        end
      end
      tick();
    end
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL midrst_ptr: got %b expected 0001", bus.req_ready);
    end
    bus.req_valid = 4'b0100;
    bus.req_a[8 +: 4] = 4'd5;
    bus.req_b[8 +: 4] = 4'd6;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++; $display("FAIL midrst_grant2: got %b expected 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== (c == 4)) begin
        errors++; $display("FAIL midrst_rsp_valid2 c%0d: got %b expected %b", c, bus.rsp_valid, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if ({bus.rsp_id, bus.rsp_data} !== {2'd2, 8'd30}) begin
          errors++; $display("FAIL midrst_rsp: got id %0d data %0d expected id 2 data 30", bus.rsp_id, bus.rsp_data);
        end
      end
      tick();
    end
  endtask

`ifdef MUL_SCHED_PERF_EN
  task automatic test_perf();
    do_reset();
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 4; c++) tick();
    bus.req_valid = 4'b0000;
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.perf_issue_cnt, bus.perf_stall_cnt} !== {16'd4, 16'd0}) begin
      errors++; $display("FAIL perf_issue: got issue %0d stall %0d expected 4 0", bus.perf_issue_cnt, bus.perf_stall_cnt);
    end
    tick();
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) tick();
    bus.req_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if ({bus.perf_issue_cnt, bus.perf_stall_cnt} !== {16'd4, 16'd5}) begin
      errors++; $display("FAIL perf_stall: got issue %0d stall %0d expected 4 5", bus.perf_issue_cnt, bus.perf_stall_cnt);
    end
    bus.flush = 1'b0;
    tick();
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.flush = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_flush();
    test_reset_midop();
`ifdef MUL_SCHED_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_sched.md
Name: mul_sched

Overview:
- Round-robin scheduler that shares one pipelined multiplier between N_REQ requesters.
- Accepts one operand pair per cycle from the granted requester and drives the multiplier issue port.
- Carries each requester ID down a tag pipeline matched to the multiplier latency, then returns each product tagged with its ID.
- Provides a flush/drain handshake so upstream control can quiesce the multiplier before reconfiguration.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- W, 4, operand width; product width is 2*W
- LAT, 2, multiplier latency: cycles from the sampling edge of mul_vld to mul_res being valid (1..8)
- ID_W, $clog2(N_REQ), width of the requester ID (derived; not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  N_REQ  per-requester operand valid
- req_a  in  N_REQ*W  operand A; requester i uses bits [i*W +: W]
- req_b  in  N_REQ*W  operand B, same packing as req_a
- req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- mul_a  out  W  registered operand A to the multiplier
- mul_b  out  W  registered operand B to the multiplier
- mul_vld  out  1  registered issue strobe to the multiplier
- mul_res  in  2*W  multiplier product, valid LAT cycles after the issue
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  ID_W  requester ID of the result
- rsp_data  out  2*W  product
- flush  in  1  drain request (level)
- flush_done  out  1  pipeline empty and issue blocked
- busy  out  1  at least one operation in flight

Behaviour:
- Reset values:
  - outputs: mul_a=0, mul_b=0, mul_vld=0, rsp_valid=0, rsp_id=0, rsp_data=0, flush_done=0, busy=0
  - internal: round-robin pointer ptr=0, tag pipeline cleared, state=RUN
- Arbitration:
  - In RUN, req_ready is combinational from req_valid and ptr.
  - Grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, … with wrap at N_REQ.
  - req_ready is all-zero when no request is valid or state≠RUN.
  - After a grant to i, ptr ← (i+1) mod N_REQ. ptr is unchanged when there is no grant.
- Issue:
  - A transfer accepted in cycle t registers mul_a/mul_b/mul_vld=1 at the end of t, so they are visible in cycle t+1.
  - mul_vld=0 in cycles with no transfer; mul_a/mul_b hold their last values.
  - Throughput is 1 issue per cycle. There is no backpressure from the multiplier.
- Tag pipeline:
  - {vld,id} shift register of depth LAT+1, entered in step with mul_vld.
  - Its output aligns with mul_res in cycle t+1+LAT.
  - At the end of that cycle, rsp_valid/rsp_id/rsp_data are registered from the tag output and mul_res.
  - Latency from accept to rsp_valid is LAT+2 cycles, so 4 with defaults.
  - rsp_valid is a single-cycle pulse per result; rsp_data/rsp_id hold between pulses.
  - Results are returned in issue order. There is no result backpressure.
- busy = mul_vld | any tag-pipeline vld | rsp_valid.
- FSM:
  - RUN: normal operation. flush=1 sampled → DRAIN; the cycle after that edge sees req_ready=0. An accept in the same cycle flush rises still completes.
  - DRAIN: req_ready=0. When busy=0 → DONE.
  - DONE: flush_done=1, req_ready=0. flush=0 → RUN; flush_done drops in the same edge.
  - flush deasserted while in DRAIN → stays in DRAIN until empty, then DONE, then RUN on the next cycle because flush=0. No results are lost.
- Reset mid-operation: the tag pipeline is cleared, so products arriving after reset produce no rsp_valid. ptr returns to 0.
- Width: rsp_data = mul_res unchanged (2*W bits); the block performs no arithmetic.

Optional Feature:
- MUL_SCHED_PERF_EN defined:
  - adds output perf_issue_cnt[15:0], counting accepted transfers;
  - adds output perf_stall_cnt[15:0], counting cycles with any req_valid=1 and no grant;
  - both saturate at 16'hFFFF and clear on rst.
- Not defined: these ports and their logic are absent, and the behaviour above is unchanged.

Test Plan:
- Defaults; the bench models the multiplier with LAT=2. req_valid=4'b0001, a=3, b=5, accepted in cycle 0 → mul_vld=1 in cycle 1; rsp_valid=1, rsp_id=0, rsp_data=8'd15 in cycle 4 only.
- req_valid=4'b1111 held for 8 cycles, operands i*2 and 3 → grants 0,1,2,3,0,1,2,3; one rsp per cycle from cycle 4; products 0,6,12,18 repeating.
- Grant to 0 (ptr=1), then req_valid=4'b1010 → grant 1 then 3. Then req_valid=4'b0001 → grant 0 after wrap.
- Three accepts in cycles 0–2, flush=1 sampled in cycle 2 → req_ready=0 from cycle 3; rsp in cycles 4–6; flush_done=1 from cycle 8 (DRAIN→DONE when busy=0); flush=0 → req_ready returns the next cycle.
- Accepts in cycles 0 and 1, rst=1 in cycle 2 → rsp_valid stays 0 for 10 cycles; ptr=0; a request from requester 2 afterwards is granted normally.
- With MUL_SCHED_PERF_EN: 4 requesters valid for 4 cycles → perf_issue_cnt=4, perf_stall_cnt=0. Then flush with requests pending for 5 cycles → perf_stall_cnt=5.
